instr_encoder_writer: RTL
=========================

Name: instr_encoder_writer

Overview:
- Inverse of the core's instruction decoder: accepts symbolic instruction records over a valid/ready stream and encodes each into a 32-bit MIPS32 word.
- Writes the encoded words sequentially into instruction memory through a buffered write port with backpressure.
- Used by the self-test/boot path to build programs in imem before releasing the core. Supports exactly the decoder's instruction set.

Parameters:
- ADDR_W, 10, word-address width of the imem write port; the address counter wraps modulo 2^ADDR_W.
- DEPTH, 2, output FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; loads base_addr and begins a program
- base_addr  in  ADDR_W  first word address of the program
- finish  in  1  one-cycle pulse; no more records follow, drain and stop
- in_valid  in  1  record valid
- in_ready  out  1  record accepted when in_valid && in_ready
- in_op  in  asm_op_t  instruction mnemonic
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields
- in_imm16  in  16  immediate
- in_target  in  26  jump target field
- mem_we  out  1  write request (FIFO non-empty)
- mem_ready  in  1  memory accepts; a write fires when mem_we && mem_ready
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded word
- words_written  out  ADDR_W+1  count of fired writes since start
- err_invalid  out  1  sticky: an unsupported op was accepted
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO empty, mem_addr=0, words_written=0, err_invalid=0, in_ready=0, mem_we=0, busy=0, done=0. Reset mid-program discards all buffered words; no write fires after reset.
- States and transitions:
  - IDLE --start--> RUN
  - RUN --finish--> DRAIN
  - DRAIN --FIFO empty--> DONE
  - DONE --start--> RUN
  - start while in RUN or DRAIN is ignored. finish while in IDLE or DONE is ignored.
- On start: mem_addr <= base_addr; words_written <= 0; err_invalid <= 0. FIFO is already empty in IDLE and DONE.
- in_ready = (state==RUN) && (fifo_count < DEPTH). Combinational from state and count only; never depends on in_valid.
- finish together with an accepted record in the same cycle: the record is encoded and enqueued, then the state goes to DRAIN.
- Encoding is combinational on the accepted record; the word is enqueued in the same cycle. mem_wdata and mem_we are driven from the FIFO head register, so the earliest write is 1 cycle after acceptance.
- Encoding rules (fields not listed are zero):
  - R-type word is {6'h00, rs, rt, rd, shamt, funct}:
    - ADDU funct 21, SUBU 23, OR 25, XOR 26: shamt forced to 0.
    - SLL funct 00, SRL 02: rs forced to 0.
    - JR funct 08: rs only.
    - SYSCALL: word is 0x0000000C.
  - I-type word is {op, rs, rt, imm16}, op in hex: ANDI 0c, ORI 0d, XORI 0e, ADDIU 09, SLTI 0a, LW 23, SW 2b, BEQ 04, BNE 05. LUI 0f with rs forced to 0.
  - J-type word is {op, target}: J 02, JAL 03.
- Invalid op: the handshake still completes, nothing is enqueued, err_invalid is set and stays set until the next start.
- A fired write increments mem_addr (wrapping from 2^ADDR_W−1 to 0) and words_written (saturating at 2^ADDR_W).
- Simultaneous enqueue and dequeue when the FIFO is full: in_ready is already 0, so only the dequeue occurs; no combinational ready path from mem_ready to in_ready.
- mem_we stays asserted with stable addr/wdata until mem_ready.

Decomposition:
- Shared package, alongside the existing instruction typedefs:
  - asm_op_t enum: ASM_ADDU, ASM_SUBU, ASM_OR, ASM_XOR, ASM_SLL, ASM_SRL, ASM_JR, ASM_SYSCALL, ASM_ANDI, ASM_ORI, ASM_XORI, ASM_ADDIU, ASM_SLTI, ASM_LUI, ASM_LW, ASM_SW, ASM_BEQ, ASM_BNE, ASM_J, ASM_JAL, ASM_INVALID.
  - Opcode and funct localparams shared with the decoder.
  - A pure encode function.
- One sub-module: sync_fifo (parameterised width/depth, count output).

Test Plan:
- start base_addr=0x010; ADDIU rs=0 rt=8 imm=0x0005; finish, mem_ready=1 -> one write at addr 0x010, data 0x24080005; words_written=1; done=1.
- Each supported op with a known record -> data matches the decoder round trip:
  - ADDU rd=3 rs=1 rt=2 -> 0x00221821
  - SW rt=9 rs=29 imm=4 -> 0xAFA90004
  - LUI rt=1 imm=0x1234 -> 0x3C011234
  - JAL target=0x0100000 -> 0x0C100000
  - SYSCALL -> 0x0000000C
- mem_ready=0 for 10 cycles with 5 records offered -> exactly DEPTH accepted, in_ready=0 afterwards, mem_we held with stable addr/data; then all 5 written in order.
- ASM_INVALID between two valid records -> 2 writes at consecutive addresses; err_invalid=1 until the next start.
- base_addr=2^ADDR_W−1, three records -> addresses 0x3FF, 0x000, 0x001.
- rst_n low while the FIFO holds 2 words -> mem_we=0 immediately, no further writes, state IDLE; finish with an accepted record in the same cycle -> that record is written before done.

Source files
------------

// File: rtl/instr_encoder_writer_pkg.sv
// Instruction-set definitions shared with the core decoder, plus the symbolic
// record type and the pure MIPS32 encode function used by the imem writer.
package instr_encoder_writer_pkg;

    typedef enum logic [4:0] {
        ASM_ADDU, ASM_SUBU, ASM_OR, ASM_XOR, ASM_SLL, ASM_SRL, ASM_JR, ASM_SYSCALL,
        ASM_ANDI, ASM_ORI, ASM_XORI, ASM_ADDIU, ASM_SLTI, ASM_LUI, ASM_LW, ASM_SW,
        ASM_BEQ, ASM_BNE, ASM_J, ASM_JAL, ASM_INVALID
    } asm_op_t;

    typedef enum logic [1:0] {
        S_IDLE, S_RUN, S_DRAIN, S_DONE
    } ew_state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0c;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;

    typedef struct packed {
        asm_op_t     op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm16;
        logic [25:0] target;
    } asm_rec_t;

    typedef struct packed {
        logic        ok;
        logic [31:0] word;
    } enc_t;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OP_SPECIAL, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic enc_t encode(input asm_rec_t r);
        enc_t e;
        e.ok   = 1'b1;
        e.word = '0;
        case (r.op)
            ASM_ADDU:    e.word = r_word(r.rs, r.rt, r.rd, 5'd0, FN_ADDU);
            ASM_SUBU:    e.word = r_word(r.rs, r.rt, r.rd, 5'd0, FN_SUBU);
            ASM_OR:      e.word = r_word(r.rs, r.rt, r.rd, 5'd0, FN_OR);
            ASM_XOR:     e.word = r_word(r.rs, r.rt, r.rd, 5'd0, FN_XOR);
            ASM_SLL:     e.word = r_word(5'd0, r.rt, r.rd, r.shamt, FN_SLL);
            ASM_SRL:     e.word = r_word(5'd0, r.rt, r.rd, r.shamt, FN_SRL);
            ASM_JR:      e.word = r_word(r.rs, 5'd0, 5'd0, 5'd0, FN_JR);
            ASM_SYSCALL: e.word = r_word(5'd0, 5'd0, 5'd0, 5'd0, FN_SYSCALL);
            ASM_ANDI:    e.word = i_word(OP_ANDI, r.rs, r.rt, r.imm16);
            ASM_ORI:     e.word = i_word(OP_ORI, r.rs, r.rt, r.imm16);
            ASM_XORI:    e.word = i_word(OP_XORI, r.rs, r.rt, r.imm16);
            ASM_ADDIU:   e.word = i_word(OP_ADDIU, r.rs, r.rt, r.imm16);
            ASM_SLTI:    e.word = i_word(OP_SLTI, r.rs, r.rt, r.imm16);
            ASM_LUI:     e.word = i_word(OP_LUI, 5'd0, r.rt, r.imm16);
            ASM_LW:      e.word = i_word(OP_LW, r.rs, r.rt, r.imm16);
            ASM_SW:      e.word = i_word(OP_SW, r.rs, r.rt, r.imm16);
            ASM_BEQ:     e.word = i_word(OP_BEQ, r.rs, r.rt, r.imm16);
            ASM_BNE:     e.word = i_word(OP_BNE, r.rs, r.rt, r.imm16);
            ASM_J:       e.word = {OP_J, r.target};
            ASM_JAL:     e.word = {OP_JAL, r.target};
            default:     e.ok   = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/instr_encoder_writer_sync_fifo.sv
// Synchronous FIFO with registered storage; head is the entry at the read pointer.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder_writer.sv
// Encodes symbolic instruction records into MIPS32 words and streams them
// into instruction memory at consecutive word addresses through a small FIFO.
module instr_encoder_writer
    import instr_encoder_writer_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  asm_op_t           in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm16,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   words_written,
    output logic              err_invalid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    ew_state_t        state;
    ew_state_t        state_next;
    logic             load;
    asm_rec_t         rec;
    enc_t             enc;
    logic             accept;
    logic             fire;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    always_comb begin
        rec = '{op: in_op, rs: in_rs, rt: in_rt, rd: in_rd, shamt: in_shamt,
                imm16: in_imm16, target: in_target};
        enc = encode(rec);
    end

    assign in_ready = (state == S_RUN) && (fifo_count < CNT_W'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign mem_we   = !fifo_empty;
    assign fire     = mem_we && mem_ready;
    assign busy     = (state == S_RUN) || (state == S_DRAIN);
    assign done     = (state == S_DONE);

    sync_fifo #(
        .WIDTH(32),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (accept && enc.ok),
        .push_data(enc.word),
        .pop      (fire),
        .head     (mem_wdata),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_RUN;
                    load       = 1'b1;
                end
            end
            S_RUN:   if (finish) state_next = S_DRAIN;
            S_DRAIN: if (fifo_empty) state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // The count MSB is only set at the saturation value 2^ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr      <= '0;
            words_written <= '0;
            err_invalid   <= 1'b0;
        end else if (load) begin
            mem_addr      <= base_addr;
            words_written <= '0;
            err_invalid   <= 1'b0;
        end else begin
            if (fire) begin
                mem_addr <= mem_addr + 1'b1;
                if (!words_written[ADDR_W]) words_written <= words_written + 1'b1;
            end
            if (accept && !enc.ok) err_invalid <= 1'b1;
        end
    end

endmodule
